rotate16_issue_stage: RTL and testbench

//  Sequential issue/retire stage wrapped around the 16-bit combinational right rotator (Rrotate16_gen).

---
 rtl/rotate16_issue_stage.sv | 126 ++++++++++++
 tb/tb_rotate16_issue_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rotate16_issue_stage.sv
// Issue/retire stage around an external 16-bit combinational right rotator: request FIFO in, registered result slot out.
// Optional left rotation via the ROT16_LEFT_EN macro (adds in_dir and per-entry direction storage).
module rotate16_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_a,
    input  logic [3:0]      in_shr,
`ifdef ROT16_LEFT_EN
    input  logic            in_dir,
`endif
    output logic [15:0]     rot_a,
    output logic [3:0]      rot_shr,
    input  logic [15:0]     rot_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic [3:0]      out_shr,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    logic [15:0]   mem_a   [DEPTH];
    logic [3:0]    mem_shr [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, push, pop;
    logic [3:0]    head_shr;
    state_t        state;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && ((state == S_EMPTY) || out_ready);
    assign head_shr = empty ? 4'd0 : mem_shr[rd_ptr];
    assign rot_a    = empty ? 16'd0 : mem_a[rd_ptr];

`ifdef ROT16_LEFT_EN
    logic mem_dir [DEPTH];
    logic head_dir;

    // Left by n equals right by (16-n) mod 16; left by 0 stays 0.
    function automatic logic [3:0] left_to_right(input logic [3:0] shr);
        return 4'd0 - shr;
    endfunction

    assign head_dir = empty ? 1'b0 : mem_dir[rd_ptr];
    assign rot_shr  = head_dir ? left_to_right(head_shr) : head_shr;

    always_ff @(posedge clk) begin
        if (push) mem_dir[wr_ptr] <= in_dir;
    end
`else
    assign rot_shr = head_shr;
`endif

    assign out_valid = (state == S_FULL);
    assign busy      = !empty || out_valid;

    // FIFO storage: data only, no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_shr[wr_ptr] <= in_shr;
        end
    end

    // FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result slot FSM with retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_EMPTY;
            out_data <= 16'd0;
            out_shr  <= 4'd0;
            op_count <= '0;
        end else begin
            if (state == S_FULL && out_ready) op_count <= op_count + 1'b1;
            case (state)
                S_EMPTY: begin
                    if (!empty) begin
                        out_data <= rot_out;
                        out_shr  <= head_shr;
                        state    <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        if (!empty) begin
                            out_data <= rot_out;
                            out_shr  <= head_shr;
                        end else begin
                            state <= S_EMPTY;
                        end
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate16_issue_stage.sv
// Directed bench for rotate16_issue_stage; a behavioural right rotator closes the rot_a/rot_shr -> rot_out loop.
module tb_rotate16_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [3:0]  in_shr = 4'd0;
    logic        in_dir = 1'b0;
    logic [15:0] rot_a;
    logic [3:0]  rot_shr;
    logic [15:0] rot_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_shr;
    logic        busy;
    logic [3:0]  op_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign rot_out = 16'({rot_a, rot_a} >> rot_shr);

    rotate16_issue_stage #(.DEPTH(4), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_shr(in_shr),
`ifdef ROT16_LEFT_EN
        .in_dir(in_dir),
`endif
        .rot_a(rot_a), .rot_shr(rot_shr), .rot_out(rot_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_shr(out_shr),
        .busy(busy), .op_count(op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_dir = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
        total++; if (out_shr !== 4'h0) begin bad++; $display("FAIL rst_out_shr got=%h exp=0", out_shr); end
        total++; if (op_count !== 4'h0) begin bad++; $display("FAIL rst_op_count got=%h exp=0", op_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (rot_a !== 16'h0000 || rot_shr !== 4'h0) begin bad++; $display("FAIL rst_rot got=%h/%h exp=0000/0", rot_a, rot_shr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h0030; in_shr = 4'd8;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
        total++; if (rot_a !== 16'h0030 || rot_shr !== 4'd8) begin bad++; $display("FAIL single_head got=%h/%h exp=0030/8", rot_a, rot_shr); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 16'h3000) begin bad++; $display("FAIL single_data got=%h exp=3000", out_data); end
        total++; if (out_shr !== 4'd8) begin bad++; $display("FAIL single_shr got=%h exp=8", out_shr); end
        step();
        total++; if (op_count !== 4'd1) begin bad++; $display("FAIL single_count got=%h exp=1", op_count); end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b exp=0/0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [5];
        logic [3:0]  vs [5];
        logic [15:0] ve [5];
        va = '{16'h0001, 16'h0003, 16'h00F0, 16'h1234, 16'hABCD};
        vs = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd8};
        ve = '{16'h8000, 16'hC000, 16'h000F, 16'h4123, 16'hCDAB};
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=1", i, in_ready); end
            in_valid = 1'b1; in_a = va[i]; in_shr = vs[i];
            step();
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        in_a = 16'hDEAD; in_shr = 4'd3;
        step();
        in_valid = 1'b0;
        total++; if (out_data !== 16'h8000 || out_shr !== 4'd1) begin bad++; $display("FAIL bp_hold got=%h/%h exp=8000/1", out_data, out_shr); end
        total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_still_full got=%b/%b exp=0/1", in_ready, busy); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== ve[i] || out_shr !== vs[i])
                begin bad++; $display("FAIL bp_res_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_data, out_shr, ve[i], vs[i]); end
            step();
        end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b/%b exp=0/0", out_valid, busy); end
        total++; if (op_count !== 4'd5) begin bad++; $display("FAIL bp_count got=%h exp=5", op_count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h8001; in_shr = 4'd1;
        step();
        in_shr = 4'd0;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hC000) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/c000", out_valid, out_data); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 16'h8001) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/8001", out_valid, out_data); end
        step();
        total++; if (out_valid !== 1'b0 || op_count !== 4'd2) begin bad++; $display("FAIL b2b_end got=%b/%h exp=0/2", out_valid, op_count); end
    endtask

`ifdef ROT16_LEFT_EN
    task automatic test_left();
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h0030; in_shr = 4'd4; in_dir = 1'b1;
        step();
        in_shr = 4'd0;
        total++; if (rot_shr !== 4'd12) begin bad++; $display("FAIL left_rot_shr got=%0d exp=12", rot_shr); end
        step();
        in_valid = 1'b0; in_dir = 1'b0;
        total++; if (out_data !== 16'h0300 || out_shr !== 4'd4) begin bad++; $display("FAIL left4 got=%h/%h exp=0300/4", out_data, out_shr); end
        total++; if (rot_shr !== 4'd0) begin bad++; $display("FAIL left0_rot_shr got=%0d exp=0", rot_shr); end
        step();
        total++; if (out_data !== 16'h0030 || out_shr !== 4'd0) begin bad++; $display("FAIL left0 got=%h/%h exp=0030/0", out_data, out_shr); end
        step();
    endtask
`endif

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'h0F00 + 16'(i); in_shr = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || op_count !== 4'd2) begin bad++; $display("FAIL mid_pre got=%b/%h exp=1/2", out_valid, op_count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%b exp=0/0", out_valid, busy); end
        total++; if (in_ready !== 1'b1 || op_count !== 4'd0) begin bad++; $display("FAIL mid_async2 got=%b/%h exp=1/0", in_ready, op_count); end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d got=%b/%b exp=0/0", i, out_valid, busy); end
        end
    endtask

    task automatic test_count_wrap();
        int n;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_a = 16'(i); in_shr = 4'd0;
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_drain_timeout got=%b exp=0", busy); end
        total++; if (op_count !== 4'hF) begin bad++; $display("FAIL wrap_max got=%h exp=f", op_count); end
        in_valid = 1'b1; in_a = 16'h0001;
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || op_count !== 4'hF) begin bad++; $display("FAIL wrap_pending got=%b/%h exp=1/f", out_valid, op_count); end
        step();
        total++; if (op_count !== 4'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
`ifdef ROT16_LEFT_EN
        test_left();
`endif
        test_reset_midstream();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
